// File: rtl/delay_tap_ctrl_gea0.sv
// Delay-chain tap capture: two-rank synchroniser, thermometer decode,
// and averaged tap-count measurement with sticky edge/bubble flags.
module delay_tap_ctrl_gea0 #(
    parameter int NTAPS = 16,
    parameter int AVG_LOG2 = 2,
    localparam int CW = $clog2(NTAPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NTAPS-1:0] taps,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    output logic [CW-1:0]    code,
    output logic             ovf,
    output logic             unf,
    output logic             bubble
);

    localparam int AW = CW + AVG_LOG2;
    localparam int NW = AVG_LOG2 + 1;
    localparam int NSAMP = 1 << AVG_LOG2;
    localparam logic [NW-1:0] LAST = NW'(NSAMP - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACCUM,
        DONE
    } state_t;

    state_t           state_q;
    logic [NTAPS-1:0] s1_q, s2_q;
    logic [NW-1:0]    cnt_q;
    logic [AW-1:0]    acc_q, acc_d;
    logic             ovf_s_q, unf_s_q, bub_s_q;
    logic             ovf_s_d, unf_s_d, bub_s_d;
    logic             busy_q, valid_q, ovf_q, unf_q, bubble_q;
    logic [CW-1:0]    code_q, code_d;
    logic [CW-1:0]    cnt_dec;
    logic             bub_dec;
    logic             seen_zero;

    // Leading run of ones from bit0; any 1 past the first 0 is a bubble.
    always_comb begin
        cnt_dec   = '0;
        bub_dec   = 1'b0;
        seen_zero = 1'b0;
        for (int i = 0; i < NTAPS; i++) begin
            if (!seen_zero) begin
                if (s2_q[i]) cnt_dec = cnt_dec + CW'(1);
                else         seen_zero = 1'b1;
            end else if (s2_q[i]) begin
                bub_dec = 1'b1;
            end
        end
    end

    always_comb begin
        acc_d   = acc_q + AW'(cnt_dec);
        ovf_s_d = ovf_s_q | (cnt_dec == CW'(NTAPS));
        unf_s_d = unf_s_q | (cnt_dec == '0);
        bub_s_d = bub_s_q | bub_dec;
        code_d  = CW'(acc_d >> AVG_LOG2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            s1_q     <= '0;
            s2_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            ovf_s_q  <= 1'b0;
            unf_s_q  <= 1'b0;
            bub_s_q  <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            code_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            bubble_q <= 1'b0;
        end else begin
            s1_q    <= taps;
            s2_q    <= s1_q;
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SETTLE;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        ovf_s_q <= 1'b0;
                        unf_s_q <= 1'b0;
                        bub_s_q <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (cnt_q == NW'(1)) begin
                        state_q <= ACCUM;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + NW'(1);
                    end
                end
                ACCUM: begin
                    acc_q   <= acc_d;
                    ovf_s_q <= ovf_s_d;
                    unf_s_q <= unf_s_d;
                    bub_s_q <= bub_s_d;
                    // Results load together with valid, including the last sample.
                    if (cnt_q == LAST) begin
                        state_q  <= DONE;
                        valid_q  <= 1'b1;
                        code_q   <= code_d;
                        ovf_q    <= ovf_s_d;
                        unf_q    <= unf_s_d;
                        bubble_q <= bub_s_d;
                    end else begin
                        cnt_q <= cnt_q + NW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign code   = code_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign bubble = bubble_q;

endmodule
